apb_master_arbiter: RTL

- Round-robin APB master that shares one APB slave (the 16-word APB memory slave) among NUM_REQ local requesters.
- Accepts one request at a time and runs the APB SETUP/ACCESS sequence.
- Returns read data or error status to the winning requester.
- Sits between the on-chip request sources and the APB bus; aborts hung transfers with a timeout.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_rr_arbiter.sv | 31 +++
 rtl/apb_master_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and constants: bus widths, master FSM states and the default timeout.
package apb_pkg;

  localparam int ADDR_WIDTH          = 8;
  localparam int DATA_WIDTH          = 32;
  localparam int MST_DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    MST_IDLE   = 2'd0,
    MST_SETUP  = 2'd1,
    MST_ACCESS = 2'd2
  } apb_master_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the pointer, with wrap.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: accepts one local request at a time, runs SETUP/ACCESS,
// and returns read data / error / timeout status to the winning requester.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = apb_pkg::MST_DEFAULT_TIMEOUT,
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           rsp_timeout,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH-1:0]          prdata,
  input  logic                           pready,
  input  logic                           pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_master_state_t r_state, w_nextState;

  logic [IDX_W-1:0]      r_ptr, r_id, w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any;
  logic [7:0]            r_cnt;
  logic                  w_timeout, w_done;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [NUM_REQ-1:0]    r_rspValid;
  logic [DATA_WIDTH-1:0] r_rspRdata;
  logic                  r_rspErr, r_rspTimeout;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  assign w_done    = pready | pslverr | w_timeout;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= MST_IDLE;
    else          r_state <= w_nextState;
  end

  // Grant is combinational in IDLE but suppressed while reset is held.
  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    psel        = 1'b0;
    penable     = 1'b0;
    case (r_state)
      MST_IDLE: begin
        if (w_any) begin
          req_ready   = presetn ? w_grant : '0;
          w_nextState = MST_SETUP;
        end
      end
      MST_SETUP: begin
        psel        = 1'b1;
        w_nextState = MST_ACCESS;
      end
      MST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (w_done) w_nextState = MST_IDLE;
      end
      default: w_nextState = MST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_rspValid   <= '0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
    end else begin
      r_rspValid   <= '0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
      case (r_state)
        MST_IDLE: begin
          if (w_any) begin
            r_id     <= w_idx;
            r_paddr  <= req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_pwdata <= req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_pwrite <= req_write[w_idx];
          end
        end
        MST_SETUP: r_cnt <= '0;
        MST_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done) begin
            r_rspValid   <= NUM_REQ'(1) << r_id;
            r_rspRdata   <= (!r_pwrite && pready && !pslverr) ? prdata : '0;
            r_rspErr     <= pslverr | w_timeout;
            r_rspTimeout <= w_timeout & ~(pready | pslverr);
            r_ptr        <= (r_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rspValid;
  assign rsp_rdata   = r_rspRdata;
  assign rsp_err     = r_rspErr;
  assign rsp_timeout = r_rspTimeout;

endmodule
